imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Fetch-stage sequencer in front of the instruction memory.
- Owns the PC and issues one word request at a time to a memory with fixed latency.
- Presents the fetched instruction to decode through a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that lands while a request is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_LATENCY, 1, cycles from the mem_req cycle to the mem_rvalid cycle. Legal range 1..4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- redirect_valid  in  1  decode/execute requests a PC change
- redirect_pc  in  32  new PC
- mem_req  out  1  request strobe to instruction memory
- mem_addr  out  32  byte address of the request (always word-aligned)
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_pc  out  32  PC of the presented instruction
- out_instr  out  32  presented instruction
- misalign_err  out  1  sticky: a redirect_pc had bits [1:0] nonzero

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=ISSUE, wait counter=0, discard=0.
  - out_valid=0, out_pc=0, out_instr=0, misalign_err=0.
  - mem_req is decoded from state, so it is 1 in the first cycle after reset release.
- States:
  - ISSUE: mem_req=1, mem_addr=pc. Next state is WAIT, and the counter loads MEM_LATENCY.
  - WAIT: mem_req=0. The counter decrements each cycle.
    - On mem_rvalid with discard=0: capture mem_rdata into out_instr and pc into out_pc, set out_valid=1, go to HOLD.
    - On mem_rvalid with discard=1: clear discard, go to ISSUE. No output is produced.
  - HOLD: out_valid=1, and out_pc/out_instr stay stable until the handshake completes.
    - On out_valid && out_ready: pc<=pc+4 (mod 2^32, wraps silently), out_valid<=0, go to ISSUE.
- mem_rvalid outside WAIT is ignored. The bench flags it as a protocol error.
- Latency per instruction is MEM_LATENCY+2 cycles with out_ready held at 1.
- Redirect has the highest priority and is acted on in the cycle it is sampled. pc<=redirect_pc with bits [1:0] forced to 00.
  - In ISSUE: the request in this cycle still uses the old pc. It is treated as in flight, so set discard=1 and go to WAIT.
  - In WAIT: set discard=1. If mem_rvalid arrives in the same cycle, drop that data and go straight to ISSUE with discard=0.
  - In HOLD: drop the held instruction, out_valid<=0, go to ISSUE. This applies even if out_ready=1 in the same cycle: redirect wins and no handshake completes.
- Misaligned redirect (redirect_pc[1:0]!=0): misalign_err<=1. It is sticky and clears only on reset.
- Back-to-back redirects: the last sampled redirect_pc wins, and discard stays 1 until the single outstanding response returns.
- At most one request is ever outstanding. mem_req never asserts while in WAIT.
- Reset asserted mid-WAIT: state returns to ISSUE immediately. The bench memory model must drop its pending response on reset.

Decomposition:
- Shared header ManBearPig.h holds:
  - the state encodings `FETCH_ISSUE=2'd0, `FETCH_WAIT=2'd1, `FETCH_HOLD=2'd2;
  - `RESET_PC_DEFAULT;
  - the existing instruction memory bounds.
- No sub-module. The latency counter is a 3-bit down-counter inline. The existing instruction memory stays outside this block, wrapped by a bench/top-level latency shim.

Test Plan:
- Reset release, MEM_LATENCY=1, memory word0=32'h2008_0005, out_ready=1:
  - mem_req in cycle 1 with addr 0;
  - out_valid in cycle 3 with out_pc=0, out_instr=32'h2008_0005;
  - next mem_addr=4.
- Stall: out_ready=0 for 5 cycles while in HOLD → out_pc/out_instr stable, no mem_req. Then out_ready=1 → one handshake, pc=4.
- Redirect in WAIT to 32'h40 (MEM_LATENCY=3) → stale response dropped, next mem_addr=32'h40, first out_pc=32'h40.
- Redirect in HOLD with out_ready=1 in the same cycle, target 32'h100 → no handshake counted, out_valid=0 next cycle, next mem_addr=32'h100.
- redirect_pc=32'h0000_0046 → mem_addr=32'h44, misalign_err=1, and it persists until rst_n=0.
- PC wrap: RESET_PC=32'hFFFF_FFFC, one accepted fetch → next mem_addr=32'h0. Also async reset during WAIT → out_valid=0 within the same cycle and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package imem_fetch_ctrl_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned LAT_MIN = 1;
    localparam int unsigned LAT_MAX = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    // Fetch sequencer states; encodings are shared with the surrounding fetch code.
    typedef enum logic [1:0] {
        FETCH_ISSUE = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_HOLD  = 2'd2
    } fetch_state_e;

    // Instruction presented to decode together with its PC.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Force a redirect target onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    // A redirect target that is not word aligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: redirect input, instruction memory port and decode handshake.
interface imem_fetch_ctrl_if;
    import imem_fetch_ctrl_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            misalign_err;

    // Fetch controller side.
    modport master (
        input  redirect_valid, redirect_pc, mem_rvalid, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, out_pc, out_instr, misalign_err
    );

    // Environment side: redirect source, memory and decode.
    modport slave (
        output redirect_valid, redirect_pc, mem_rvalid, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, out_pc, out_instr, misalign_err
    );

endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues one word request at a time to a
// fixed-latency instruction memory and hands instructions to decode.
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned     MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    imem_fetch_ctrl_if.master bus
);

    // Reject latencies the 3-bit wait counter and memory shim do not support.
    if ((MEM_LATENCY < LAT_MIN) || (MEM_LATENCY > LAT_MAX)) begin : g_bad_latency
        $error("imem_fetch_ctrl: MEM_LATENCY out of range");
    end

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    fetch_pkt_t      out_q, out_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] redir_pc_c;
    logic            redir_bad_c;

    // Aligned redirect target and misalignment flag.
    always_comb begin
        redir_pc_c  = align_pc(bus.redirect_pc);
        redir_bad_c = bus.redirect_valid && is_misaligned(bus.redirect_pc);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect always pulls the sequencer back toward ISSUE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_ISSUE: begin
                state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (bus.mem_rvalid) begin
                    if (bus.redirect_valid || discard_q) begin
                        state_d = FETCH_ISSUE;
                    end else begin
                        state_d = FETCH_HOLD;
                    end
                end
            end
            FETCH_HOLD: begin
                if (bus.redirect_valid || bus.out_ready) begin
                    state_d = FETCH_ISSUE;
                end
            end
            default: begin
                state_d = FETCH_ISSUE;
            end
        endcase
    end

    // Datapath next values: PC, discard flag, wait counter, presented packet, error.
    always_comb begin
        pc_d        = pc_q;
        discard_d   = discard_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        err_d       = err_q | redir_bad_c;

        if (bus.redirect_valid) begin
            pc_d = redir_pc_c;
        end

        unique case (state_q)
            FETCH_ISSUE: begin
                cnt_d = LAT_W'(MEM_LATENCY);
                // The request leaving this cycle still targets the old PC.
                if (bus.redirect_valid) begin
                    discard_d = 1'b1;
                end
            end
            FETCH_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
                if (bus.redirect_valid) begin
                    // Data returning with the redirect is dropped and nothing stays outstanding.
                    discard_d = !bus.mem_rvalid;
                end else if (bus.mem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        out_valid_d = 1'b1;
                        out_d.pc    = pc_q;
                        out_d.instr = bus.mem_rdata;
                    end
                end
            end
            FETCH_HOLD: begin
                if (bus.redirect_valid) begin
                    out_valid_d = 1'b0;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    pc_d        = pc_q + PC_STEP;
                end
            end
            default: begin
                discard_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            discard_q   <= discard_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end

    // Bus outputs: the request strobe is decoded straight from the state register.
    always_comb begin
        bus.mem_req      = (state_q == FETCH_ISSUE);
        bus.mem_addr     = pc_q;
        bus.out_valid    = out_valid_q;
        bus.out_pc       = out_q.pc;
        bus.out_instr    = out_q.instr;
        bus.misalign_err = err_q;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: instance A (latency 1, reset PC 0) runs a cycle
// table; instance B (latency 3, reset PC 0xFFFF_FFFC) runs redirect/wrap/reset sequences.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        redir_v   [2];
    logic [31:0] redir_pc  [2];
    logic        ready     [2];
    logic        rv        [2];
    logic [31:0] rdata     [2];
    logic        mreq      [2];
    logic [31:0] maddr     [2];
    logic        ov        [2];
    logic [31:0] opc       [2];
    logic [31:0] oinstr    [2];
    logic        err       [2];

    logic        pend      [2];
    logic [2:0]  pcnt      [2];
    logic [31:0] paddr     [2];
    logic        proto_bad = 1'b0;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if ifa ();
    imem_fetch_ctrl_if ifb ();

    assign ifa.redirect_valid = redir_v[0];
    assign ifa.redirect_pc    = redir_pc[0];
    assign ifa.out_ready      = ready[0];
    assign ifa.mem_rvalid     = rv[0];
    assign ifa.mem_rdata      = rdata[0];
    assign mreq[0]   = ifa.mem_req;
    assign maddr[0]  = ifa.mem_addr;
    assign ov[0]     = ifa.out_valid;
    assign opc[0]    = ifa.out_pc;
    assign oinstr[0] = ifa.out_instr;
    assign err[0]    = ifa.misalign_err;

    assign ifb.redirect_valid = redir_v[1];
    assign ifb.redirect_pc    = redir_pc[1];
    assign ifb.out_ready      = ready[1];
    assign ifb.mem_rvalid     = rv[1];
    assign ifb.mem_rdata      = rdata[1];
    assign mreq[1]   = ifb.mem_req;
    assign maddr[1]  = ifb.mem_addr;
    assign ov[1]     = ifb.out_valid;
    assign opc[1]    = ifb.out_pc;
    assign oinstr[1] = ifb.out_instr;
    assign err[1]    = ifb.misalign_err;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) u_a (
        .clk   (clk),
        .rst_n (rst_n[0]),
        .bus   (ifa)
    );

    imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(3)) u_b (
        .clk   (clk),
        .rst_n (rst_n[1]),
        .bus   (ifb)
    );

    function automatic int unsigned lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Memory contents: word 0 holds a known opcode, other words encode their address.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Fixed-latency memory shim per instance; drops its pending response on reset.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n[i]) begin
                pend[i] <= 1'b0;
                pcnt[i] <= 3'd0;
                rv[i]   <= 1'b0;
            end else begin
                rv[i] <= 1'b0;
                if (pend[i]) begin
                    if (pcnt[i] == 3'd1) begin
                        rv[i]    <= 1'b1;
                        rdata[i] <= mdata(paddr[i]);
                        pend[i]  <= 1'b0;
                    end else begin
                        pcnt[i] <= pcnt[i] - 3'd1;
                    end
                end
                if (mreq[i]) begin
                    if (pend[i] || rv[i] || (maddr[i][1:0] != 2'b00)) proto_bad <= 1'b1;
                    if (lat(i) == 1) begin
                        rv[i]    <= 1'b1;
                        rdata[i] <= mdata(maddr[i]);
                    end else begin
                        pend[i]  <= 1'b1;
                        pcnt[i]  <= 3'(lat(i) - 1);
                        paddr[i] <= maddr[i];
                    end
                end
            end
        end
    end

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        err;
    } vec_t;

    vec_t vt [23];

    function automatic vec_t mk(input logic r, input logic [31:0] rp, input logic rd,
                                input logic q, input logic [31:0] a, input logic v,
                                input logic [31:0] p, input logic [31:0] n, input logic e);
        vec_t t;
        t.rv = r; t.rpc = rp; t.rdy = rd; t.req = q; t.addr = a;
        t.ov = v; t.pc = p; t.ins = n; t.err = e;
        return t;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait for out_valid on instance i; n is the cycle count, 0 on timeout.
    task automatic wait_ov(input int i, input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk); #1;
            if (ov[i] === 1'b1) begin
                n = k;
                break;
            end
        end
        if (n == 0) begin
            tests++;
            errors++;
            $display("FAIL wait_ov[%0d]: no out_valid within %0d cycles", i, budget);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; redir_v[i] = 1'b0; redir_pc[i] = 32'h0; ready[i] = 1'b1;
        end

        //        rv  rpc            rdy  req addr          ov pc            instr          err
        vt[0]  = mk(0, 32'h0,        1,   1, 32'h0,        0, 32'h0,        32'h0,         0);
        vt[1]  = mk(0, 32'h0,        1,   0, 32'h0,        0, 32'h0,        32'h0,         0);
        vt[2]  = mk(0, 32'h0,        1,   0, 32'h0,        1, 32'h0,        32'h2008_0005, 0);
        vt[3]  = mk(0, 32'h0,        0,   1, 32'h4,        0, 32'h0,        32'h2008_0005, 0);
        vt[4]  = mk(0, 32'h0,        0,   0, 32'h4,        0, 32'h0,        32'h2008_0005, 0);
        for (int r = 5; r <= 9; r++)
            vt[r] = mk(0, 32'h0,     0,   0, 32'h4,        1, 32'h4,        32'hC0DE_0004, 0);
        vt[10] = mk(0, 32'h0,        1,   0, 32'h4,        1, 32'h4,        32'hC0DE_0004, 0);
        vt[11] = mk(1, 32'h46,       1,   1, 32'h8,        0, 32'h4,        32'hC0DE_0004, 0);
        vt[12] = mk(0, 32'h0,        1,   0, 32'h44,       0, 32'h4,        32'hC0DE_0004, 1);
        vt[13] = mk(0, 32'h0,        1,   1, 32'h44,       0, 32'h4,        32'hC0DE_0004, 1);
        vt[14] = mk(0, 32'h0,        1,   0, 32'h44,       0, 32'h4,        32'hC0DE_0004, 1);
        vt[15] = mk(0, 32'h0,        1,   0, 32'h44,       1, 32'h44,       32'hC0DE_0044, 1);
        vt[16] = mk(0, 32'h0,        1,   1, 32'h48,       0, 32'h44,       32'hC0DE_0044, 1);
        vt[17] = mk(0, 32'h0,        1,   0, 32'h48,       0, 32'h44,       32'hC0DE_0044, 1);
        vt[18] = mk(1, 32'h100,      1,   0, 32'h48,       1, 32'h48,       32'hC0DE_0048, 1);
        vt[19] = mk(0, 32'h0,        1,   1, 32'h100,      0, 32'h48,       32'hC0DE_0048, 1);
        vt[20] = mk(0, 32'h0,        1,   0, 32'h100,      0, 32'h48,       32'hC0DE_0048, 1);
        vt[21] = mk(0, 32'h0,        1,   0, 32'h100,      1, 32'h100,      32'hC0DE_0100, 1);
        vt[22] = mk(0, 32'h0,        1,   1, 32'h104,      0, 32'h100,      32'hC0DE_0100, 1);

        // Reset state of instance A.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check32("rst_mem_req", 32'(mreq[0]), 32'h1);
        check32("rst_mem_addr", maddr[0], 32'h0);
        check32("rst_out_valid", 32'(ov[0]), 32'h0);
        check32("rst_out_pc", opc[0], 32'h0);
        check32("rst_out_instr", oinstr[0], 32'h0);
        check32("rst_misalign", 32'(err[0]), 32'h0);

        // Cycle table on instance A starting at the first cycle after reset release.
        @(negedge clk);
        rst_n[0] = 1'b1;
        for (int r = 0; r < 23; r++) begin
            if (r != 0) @(negedge clk);
            redir_v[0] = vt[r].rv; redir_pc[0] = vt[r].rpc; ready[0] = vt[r].rdy;
            #1;
            tests++;
            if (mreq[0] !== vt[r].req || maddr[0] !== vt[r].addr || ov[0] !== vt[r].ov ||
                opc[0] !== vt[r].pc || oinstr[0] !== vt[r].ins || err[0] !== vt[r].err) begin
                errors++;
                $display("FAIL row%0d: got req=%b addr=%h ov=%b pc=%h ins=%h err=%b expected req=%b addr=%h ov=%b pc=%h ins=%h err=%b",
                         r, mreq[0], maddr[0], ov[0], opc[0], oinstr[0], err[0],
                         vt[r].req, vt[r].addr, vt[r].ov, vt[r].pc, vt[r].ins, vt[r].err);
            end
        end
        @(negedge clk);
        redir_v[0] = 1'b0; redir_pc[0] = 32'h0;
        #1;
        check32("err_sticky", 32'(err[0]), 32'h1);
        rst_n[0] = 1'b0;
        #1;
        check32("err_cleared_by_reset", 32'(err[0]), 32'h0);

        // Instance B: reset PC at the top of memory, fetch wraps to 0.
        @(negedge clk);
        rst_n[1] = 1'b1; ready[1] = 1'b1;
        #1;
        check32("b_first_req", 32'(mreq[1]), 32'h1);
        check32("b_first_addr", maddr[1], 32'hFFFF_FFFC);
        wait_ov(1, 10, n);
        check32("b_first_latency", 32'(n), 32'd4);
        check32("b_first_pc", opc[1], 32'hFFFF_FFFC);
        check32("b_first_instr", oinstr[1], 32'hC0DE_FFFC);
        @(negedge clk); #1;
        check32("b_wrap_req", 32'(mreq[1]), 32'h1);
        check32("b_wrap_addr", maddr[1], 32'h0);

        // Two redirects during WAIT: stale response dropped, last target wins.
        @(negedge clk);
        redir_v[1] = 1'b1; redir_pc[1] = 32'h80;
        #1;
        check32("b_wait_no_req", 32'(mreq[1]), 32'h0);
        @(negedge clk);
        redir_pc[1] = 32'h40;
        @(negedge clk);
        redir_v[1] = 1'b0; redir_pc[1] = 32'h0;
        #1;
        check32("b_stale_no_valid", 32'(ov[1]), 32'h0);
        @(negedge clk); #1;
        check32("b_redir_req", 32'(mreq[1]), 32'h1);
        check32("b_redir_addr", maddr[1], 32'h40);
        wait_ov(1, 10, n);
        check32("b_redir_latency", 32'(n), 32'd4);
        check32("b_redir_pc", opc[1], 32'h40);
        check32("b_redir_instr", oinstr[1], 32'hC0DE_0040);

        // Redirect in the same cycle the response returns: nothing left outstanding.
        @(negedge clk); #1;
        check32("b_next_addr", maddr[1], 32'h44);
        repeat (2) @(negedge clk);
        @(negedge clk);
        redir_v[1] = 1'b1; redir_pc[1] = 32'h200;
        @(negedge clk);
        redir_v[1] = 1'b0; redir_pc[1] = 32'h0;
        #1;
        check32("b_same_cycle_req", 32'(mreq[1]), 32'h1);
        check32("b_same_cycle_addr", maddr[1], 32'h200);
        wait_ov(1, 10, n);
        check32("b_same_cycle_latency", 32'(n), 32'd4);
        check32("b_same_cycle_pc", opc[1], 32'h200);

        // Async reset in WAIT: back to ISSUE at RESET_PC immediately.
        @(negedge clk); #1;
        check32("b_after_200_addr", maddr[1], 32'h204);
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check32("b_rst_req", 32'(mreq[1]), 32'h1);
        check32("b_rst_addr", maddr[1], 32'hFFFF_FFFC);
        check32("b_rst_valid", 32'(ov[1]), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[1] = 1'b1;
        #1;
        check32("b_restart_addr", maddr[1], 32'hFFFF_FFFC);
        wait_ov(1, 10, n);
        check32("b_restart_latency", 32'(n), 32'd4);
        check32("b_restart_pc", opc[1], 32'hFFFF_FFFC);

        // Single-outstanding and alignment observed by the memory shim throughout.
        check32("protocol", 32'(proto_bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
